// File: rtl/ecc_pkg.sv
// Shared types and constants for the extended Hamming(8,4) SECDED decoder.
// Codeword bit i carries Hamming position i+1; bit 7 is overall even parity.
package ecc_pkg;

    localparam int unsigned CW_W  = 8;
    localparam int unsigned NIB_W = 4;

    localparam int unsigned BIT_P1 = 0;
    localparam int unsigned BIT_P2 = 1;
    localparam int unsigned BIT_D1 = 2;
    localparam int unsigned BIT_P4 = 3;
    localparam int unsigned BIT_D2 = 4;
    localparam int unsigned BIT_D3 = 5;
    localparam int unsigned BIT_D4 = 6;
    localparam int unsigned BIT_P0 = 7;

    typedef enum logic {HalfLo, HalfHi} half_e;

    typedef struct packed {
        logic uncorr;
        logic corr;
    } ecc_flags_t;

    // Bit to flip for a given syndrome; only a parity failure implies a correctable error.
    function automatic logic [CW_W-1:0] syndrome_mask(input logic [2:0] syn, input logic par);
        logic [CW_W-1:0] mask;
        mask = '0;
        if (par) begin
            if (syn == 3'd0) begin
                mask[BIT_P0] = 1'b1;
            end else begin
                mask[3'(syn - 3'd1)] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/hamming84_dec.sv
// Combinational SECDED decode of one codeword: corrected nibble plus corr/uncorr flags.
module hamming84_dec
    import ecc_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [NIB_W-1:0] nibble,
    output logic             corr,
    output logic             uncorr
);

    logic [2:0]      syn;
    logic            par;
    logic [CW_W-1:0] fixed;
    logic            unused_fixed;

    always_comb begin
        syn[0] = cw[BIT_P1] ^ cw[BIT_D1] ^ cw[BIT_D2] ^ cw[BIT_D4];
        syn[1] = cw[BIT_P2] ^ cw[BIT_D1] ^ cw[BIT_D3] ^ cw[BIT_D4];
        syn[2] = cw[BIT_P4] ^ cw[BIT_D2] ^ cw[BIT_D3] ^ cw[BIT_D4];
        par    = ^cw;
        fixed  = cw ^ syndrome_mask(syn, par);
        nibble = {fixed[BIT_D4], fixed[BIT_D3], fixed[BIT_D2], fixed[BIT_D1]};
        corr   = par;
        uncorr = ~par & (|syn);
    end

    assign unused_fixed = ^{fixed[BIT_P0], fixed[BIT_P4], fixed[BIT_P2], fixed[BIT_P1]};

endmodule

// File: rtl/ecc_decoder.sv
// AXI-Stream SECDED decoder: pairs of Hamming(8,4) codewords (low nibble first) become one byte,
// with per-byte error flags and saturating error counters.
module ecc_decoder
    import ecc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [CW_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [7:0]       m_axis_tdata,
    output logic [1:0]       m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic             odd_frame
);

    logic [NIB_W-1:0] nibble;
    logic             corr;
    logic             uncorr;
    ecc_flags_t       flags;

    hamming84_dec u_dec (
        .cw     (s_axis_tdata),
        .nibble (nibble),
        .corr   (corr),
        .uncorr (uncorr)
    );

    assign flags = '{uncorr: uncorr, corr: corr};

    half_e            half_q;
    logic [NIB_W-1:0] lo_q;
    ecc_flags_t       lo_flags_q;
    logic [7:0]       m_data_q;
    logic [1:0]       m_user_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic             odd_q;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic slot_free;
    logic accept;
    logic load;

    // A low nibble without tlast only touches lo_q, so it never waits on the output slot.
    always_comb begin
        slot_free     = ~m_valid_q | m_axis_tready;
        s_axis_tready = ~ap_rst & (((half_q == HalfLo) & ~s_axis_tlast) | slot_free);
        accept        = s_axis_tvalid & s_axis_tready;
        load          = accept & ((half_q == HalfHi) | s_axis_tlast);
    end

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (accept) begin
            if (corr && !(&corr_cnt_q)) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (uncorr && !(&uncorr_cnt_q)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            half_q       <= HalfLo;
            lo_q         <= '0;
            lo_flags_q   <= '0;
            m_data_q     <= '0;
            m_user_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            odd_q        <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (accept) begin
                case (half_q)
                    HalfLo: begin
                        if (!s_axis_tlast) begin
                            lo_q       <= nibble;
                            lo_flags_q <= flags;
                            half_q     <= HalfHi;
                        end
                    end
                    HalfHi: half_q <= HalfLo;
                    default: half_q <= HalfLo;
                endcase
            end
            if (load) begin
                m_valid_q <= 1'b1;
                if (half_q == HalfHi) begin
                    m_data_q <= {nibble, lo_q};
                    m_user_q <= flags | lo_flags_q;
                    m_last_q <= s_axis_tlast;
                end else begin
                    m_data_q <= {4'h0, nibble};
                    m_user_q <= flags;
                    m_last_q <= 1'b1;
                end
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
            odd_q        <= accept & (half_q == HalfLo) & s_axis_tlast;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign odd_frame     = odd_q;
    assign corr_cnt      = corr_cnt_q;
    assign uncorr_cnt    = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_decoder.sv
// Directed bench for ecc_decoder: hand-computed codewords, output byte capture, counter checks.
module tb_ecc_decoder;

    localparam int unsigned CNT_W = 4;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic [7:0]       s_axis_tdata = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic             s_axis_tlast = 1'b0;
    logic [7:0]       m_axis_tdata;
    logic [1:0]       m_axis_tuser;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             m_axis_tlast;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;
    logic             odd_frame;

    ecc_decoder #(.CNT_W(CNT_W)) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .clr_cnt       (clr_cnt),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt),
        .odd_frame     (odd_frame)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;
    int odd_cnt = 0;
    int stab_err = 0;
    logic [10:0] out_q[$];
    logic        prev_stall = 1'b0;
    logic [10:0] prev_word = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output capture, odd_frame pulse count and AXIS hold-while-stalled check.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
            if (odd_frame)
                odd_cnt++;
            if (prev_stall && (!m_axis_tvalid ||
                               {m_axis_tlast, m_axis_tuser, m_axis_tdata} != prev_word))
                stab_err++;
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_word  = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
        end
    end

    // Called #1 after a rising edge; returns the same way once the beat is accepted.
    task automatic send(input logic [7:0] cw, input logic last);
        bit done = 0;
        int n = 0;
        s_axis_tdata  = cw;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!done && n < 100) begin
            @(negedge ap_clk);
            done = s_axis_tready;
            @(posedge ap_clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!done) check_eq("send_timeout", 32'(done), 1);
    endtask

    task automatic settle();
        repeat (3) @(posedge ap_clk);
        #1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] data, input logic [1:0] user,
                               input logic last);
        logic [10:0] got;
        got = (out_q.size() > 0) ? out_q.pop_front() : 11'h7ff;
        check_eq(tag, 32'(got), 32'({last, user, data}));
    endtask

    initial begin
        // Reset state
        @(negedge ap_clk);
        check_eq("rst_s_tready", 32'(s_axis_tready), 0);
        check_eq("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        check_eq("rst_m_tdata", 32'(m_axis_tdata), 0);
        check_eq("rst_corr_cnt", 32'(corr_cnt), 0);
        check_eq("rst_uncorr_cnt", 32'(uncorr_cnt), 0);
        check_eq("rst_odd_frame", 32'(odd_frame), 0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        check_eq("post_rst_s_tready", 32'(s_axis_tready), 1);
        @(posedge ap_clk);
        #1;

        // Clean pair
        send(8'h2D, 1'b0);
        send(8'hD2, 1'b1);
        settle();
        check_eq("t1_count", 32'(out_q.size()), 1);
        expect_byte("t1_byte", 8'hA5, 2'b00, 1'b1);
        check_eq("t1_corr_cnt", 32'(corr_cnt), 0);
        check_eq("t1_uncorr_cnt", 32'(uncorr_cnt), 0);

        // Single-bit error in low codeword
        send(8'h29, 1'b0);
        send(8'hD2, 1'b1);
        settle();
        expect_byte("t2_byte", 8'hA5, 2'b01, 1'b1);
        check_eq("t2_corr_cnt", 32'(corr_cnt), 1);
        check_eq("t2_uncorr_cnt", 32'(uncorr_cnt), 0);

        // Double-bit error in parity bits: data still A5, flagged uncorrectable
        send(8'h2E, 1'b0);
        send(8'hD2, 1'b1);
        settle();
        expect_byte("t3_byte", 8'hA5, 2'b10, 1'b1);
        check_eq("t3_uncorr_cnt", 32'(uncorr_cnt), 1);
        check_eq("t3_corr_cnt", 32'(corr_cnt), 1);
        check_eq("t3_no_odd", 32'(odd_cnt), 0);

        // Odd frame
        send(8'h2D, 1'b1);
        settle();
        expect_byte("t4_byte", 8'h05, 2'b00, 1'b1);
        check_eq("t4_odd_pulses", 32'(odd_cnt), 1);
        send(8'h2D, 1'b0);
        send(8'hD2, 1'b1);
        settle();
        expect_byte("t4_half_back", 8'hA5, 2'b00, 1'b1);

        // Backpressure: 6 beats while downstream stalls for 10 cycles
        fork
            begin
                send(8'h2D, 1'b0);
                send(8'hD2, 1'b0);
                send(8'h1E, 1'b0);
                send(8'hE1, 1'b0);
                send(8'hE1, 1'b0);
                send(8'h1E, 1'b1);
            end
            begin
                m_axis_tready = 1'b0;
                repeat (10) @(posedge ap_clk);
                #1 m_axis_tready = 1'b1;
            end
        join
        settle();
        check_eq("t5_count", 32'(out_q.size()), 3);
        expect_byte("t5_byte0", 8'hA5, 2'b00, 1'b0);
        expect_byte("t5_byte1", 8'hC3, 2'b00, 1'b0);
        expect_byte("t5_byte2", 8'h3C, 2'b00, 1'b1);
        check_eq("t5_hold_stable", 32'(stab_err), 0);

        // Saturation of corr_cnt: 20 more corrected codewords on top of 1
        for (int i = 0; i < 10; i++) begin
            send(8'h29, 1'b0);
            send(8'h52, 1'b0);
        end
        settle();
        check_eq("t6_sat_byte_count", 32'(out_q.size()), 10);
        expect_byte("t6_sat_byte", 8'hA5, 2'b01, 1'b0);
        out_q.delete();
        check_eq("t6_corr_sat", 32'(corr_cnt), 15);

        // Clear wins over a simultaneous corrected codeword
        clr_cnt = 1'b1;
        send(8'h29, 1'b0);
        clr_cnt = 1'b0;
        @(negedge ap_clk);
        check_eq("t6_clr_corr", 32'(corr_cnt), 0);
        check_eq("t6_clr_uncorr", 32'(uncorr_cnt), 0);
        @(posedge ap_clk);
        #1;
        send(8'hD2, 1'b1);
        settle();
        out_q.delete();

        // Reset mid-pair discards the held low nibble
        send(8'h2D, 1'b0);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check_eq("t6_rst_m_tvalid", 32'(m_axis_tvalid), 0);
        check_eq("t6_rst_s_tready", 32'(s_axis_tready), 0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        send(8'h2D, 1'b0);
        send(8'hD2, 1'b1);
        settle();
        check_eq("t6_after_rst_count", 32'(out_q.size()), 1);
        expect_byte("t6_after_rst_byte", 8'hA5, 2'b00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1);
    end

endmodule
